// File: rtl/regfile_param.sv
// regfile_param
// Parametrised integer register file: one synchronous write port and two
// combinational read ports. After reset a hardware sweep zeroes one register
// per clock. Reads return zero and writes are discarded until the sweep
// finishes and `ready` rises. Any write that cannot land pulses
// `write_dropped` for one cycle.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a read port whose address matches an accepted write in the
//   same cycle returns `write_data` combinationally (write-through).
//
// Parameters:
//   XLEN       data width in bits
//   ADDR_WIDTH width of all register address ports
//   NUM_REGS   number of implemented registers (2 .. 2**ADDR_WIDTH)
//   ZERO_REG   when 1, register 0 reads as zero and ignores writes
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous active-high reset; restarts the clear sweep
//   reg_write     write enable
//   rd_address    write address
//   write_data    write data
//   rs1_address   read port 1 address
//   rs2_address   read port 2 address
//   rs1_data      read port 1 data (combinational)
//   rs2_data      read port 2 data (combinational)
//   ready         high once the clear sweep has completed (registered)
//   write_dropped one-cycle pulse after a discarded write (registered)
module regfile_param #(
    parameter int XLEN       = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    input  logic [XLEN-1:0]       write_data,
    input  logic [ADDR_WIDTH-1:0] rs1_address,
    input  logic [ADDR_WIDTH-1:0] rs2_address,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic                  ready,
    output logic                  write_dropped
);

    // Storage is indexed with only as many bits as the depth needs; any
    // address at or above NUM_REGS is rejected before it reaches the array.
    localparam int                    IDX_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0]   REG_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(NUM_REGS - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [IDX_WIDTH-1:0] sweep_count;
    logic [IDX_WIDTH-1:0] sweep_next;
    logic [XLEN-1:0]      regs [NUM_REGS];
    logic                 write_hit;
    logic                 drop_now;

    // An address is usable when it is implemented and is not the hardwired
    // zero register.
    function automatic logic addr_usable(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < REG_LIMIT) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    // A write only lands in READY and never on a reset edge. Any other
    // request outside reset is reported as dropped; reset suppresses the
    // report entirely.
    assign write_hit = (state == READY) && !reset && reg_write && addr_usable(rd_address);
    assign drop_now  = !reset && reg_write && !write_hit;

    // Next-state logic: the sweep walks the counter up to the last
    // implemented register, then hands over to normal operation.
    always_comb begin
        state_next = state;
        sweep_next = sweep_count;
        case (state)
            CLEAR: begin
                sweep_next = sweep_count + IDX_WIDTH'(1);
                if (sweep_count == LAST_IDX) begin
                    state_next = READY;
                    sweep_next = '0;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = CLEAR;
                sweep_next = '0;
            end
        endcase
    end

    // Control registers. `ready` tracks the state being entered so it rises
    // on the same edge that clears the final register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= CLEAR;
            sweep_count   <= '0;
            ready         <= 1'b0;
            write_dropped <= 1'b0;
        end else begin
            state         <= state_next;
            sweep_count   <= sweep_next;
            ready         <= (state_next == READY);
            write_dropped <= drop_now;
        end
    end

    // Register array. Reset edges leave contents alone; the sweep that
    // follows is what actually clears them.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                regs[sweep_count] <= '0;
            end else if (write_hit) begin
                regs[rd_address[IDX_WIDTH-1:0]] <= write_data;
            end
        end
    end

    // Read path shared by both ports. Until the sweep completes the array
    // may still hold stale or unknown data, so reads are forced to zero.
    function automatic logic [XLEN-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [XLEN-1:0] value;
        value = '0;
        if ((state == READY) && addr_usable(addr)) begin
            value = regs[addr[IDX_WIDTH-1:0]];
`ifdef REGFILE_BYPASS_EN
            if (write_hit && (addr == rd_address)) begin
                value = write_data;
            end
`endif
        end
        return value;
    endfunction

    // Both read ports are fully independent copies of the same read path.
    always_comb begin
        rs1_data = read_port(rs1_address);
        rs2_data = read_port(rs2_address);
    end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param
// Self-checking bench for regfile_param. Three instances cover the default
// configuration (64x32, zero register), a 16-deep file with 5-bit addresses,
// and a 32-bit, 8-deep file without a zero register. Expected values are
// pushed to a scoreboard queue when stimulus is applied and popped when the
// corresponding DUT output is sampled, one sample time unit after the edge.
// Bypass expectations follow the REGFILE_BYPASS_EN macro of the build.
module tb_regfile_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Default instance
    logic        reset;
    logic        reg_write;
    logic [4:0]  rd_address;
    logic [63:0] write_data;
    logic [4:0]  rs1_address;
    logic [4:0]  rs2_address;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        ready;
    logic        write_dropped;

    // 16-register instance
    logic        reset_16;
    logic        reg_write_16;
    logic [4:0]  rd_address_16;
    logic [63:0] write_data_16;
    logic [4:0]  rs1_address_16;
    logic [4:0]  rs2_address_16;
    logic [63:0] rs1_data_16;
    logic [63:0] rs2_data_16;
    logic        ready_16;
    logic        write_dropped_16;

    // 32-bit, 8-register, no zero register instance
    logic        reset_8;
    logic        reg_write_8;
    logic [4:0]  rd_address_8;
    logic [31:0] write_data_8;
    logic [4:0]  rs1_address_8;
    logic [4:0]  rs2_address_8;
    logic [31:0] rs1_data_8;
    logic [31:0] rs2_data_8;
    logic        ready_8;
    logic        write_dropped_8;

    regfile_param dut (
        .clock(clock), .reset(reset), .reg_write(reg_write),
        .rd_address(rd_address), .write_data(write_data),
        .rs1_address(rs1_address), .rs2_address(rs2_address),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ready(ready), .write_dropped(write_dropped)
    );

    regfile_param #(.XLEN(64), .ADDR_WIDTH(5), .NUM_REGS(16), .ZERO_REG(1)) dut_16 (
        .clock(clock), .reset(reset_16), .reg_write(reg_write_16),
        .rd_address(rd_address_16), .write_data(write_data_16),
        .rs1_address(rs1_address_16), .rs2_address(rs2_address_16),
        .rs1_data(rs1_data_16), .rs2_data(rs2_data_16),
        .ready(ready_16), .write_dropped(write_dropped_16)
    );

    regfile_param #(.XLEN(32), .ADDR_WIDTH(5), .NUM_REGS(8), .ZERO_REG(0)) dut_8 (
        .clock(clock), .reset(reset_8), .reg_write(reg_write_8),
        .rd_address(rd_address_8), .write_data(write_data_8),
        .rs1_address(rs1_address_8), .rs2_address(rs2_address_8),
        .rs1_data(rs1_data_8), .rs2_data(rs2_data_8),
        .ready(ready_8), .write_dropped(write_dropped_8)
    );

    int          compared   = 0;
    int          mismatched = 0;
    logic [63:0] exp_q [$];
    logic [63:0] expv;
    logic [63:0] model [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Advance to one time unit past the next rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 64'd0 : model[a];
    endfunction

    task automatic clear_model;
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
    endtask

    // Reset state, first sweep, then a sweep over a preloaded register.
    task automatic test_reset;
        int edges;
        reset = 1'b1; rs1_address = 5'd7; rs2_address = 5'd7;
        tick; tick;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        expv = exp_q.pop_front(); compared++;
        if (64'(ready) !== expv) begin mismatched++; $display("[TB] FAIL reset_ready: got %h expected %h", ready, expv); end
        expv = exp_q.pop_front(); compared++;
        if (64'(write_dropped) !== expv) begin mismatched++; $display("[TB] FAIL reset_dropped: got %h expected %h", write_dropped, expv); end
        expv = exp_q.pop_front(); compared++;
        if (rs1_data !== expv) begin mismatched++; $display("[TB] FAIL reset_rs1: got %h expected %h", rs1_data, expv); end

        reset = 1'b0;
        exp_q.push_back(64'd32);
        edges = 0;
        while (ready !== 1'b1 && edges < 100) begin tick; edges++; end
        expv = exp_q.pop_front(); compared++;
        if (64'(edges) !== expv) begin mismatched++; $display("[TB] FAIL first_sweep_len: got %0d expected %0d", edges, expv); end

        reg_write = 1'b1; rd_address = 5'd7; write_data = 64'hDEAD;
        exp_q.push_back(64'hDEAD);
        tick;
        reg_write = 1'b0;
        expv = exp_q.pop_front(); compared++;
        if (rs1_data !== expv) begin mismatched++; $display("[TB] FAIL preload_x7: got %h expected %h", rs1_data, expv); end

        reset = 1'b1; tick; reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            exp_q.push_back(64'(i == 32));
            exp_q.push_back(64'd0);
            tick;
            expv = exp_q.pop_front(); compared++;
            if (64'(ready) !== expv) begin mismatched++; $display("[TB] FAIL sweep_ready edge %0d: got %h expected %h", i, ready, expv); end
            expv = exp_q.pop_front(); compared++;
            if (rs1_data !== expv) begin mismatched++; $display("[TB] FAIL sweep_rs1 edge %0d: got %h expected %h", i, rs1_data, expv); end
        end
        tick;
        exp_q.push_back(64'd0);
        expv = exp_q.pop_front(); compared++;
        if (rs1_data !== expv) begin mismatched++; $display("[TB] FAIL post_sweep_x7: got %h expected %h", rs1_data, expv); end
        clear_model();
    endtask

    task automatic test_basic_write;
        reg_write = 1'b1; rd_address = 5'd5; write_data = 64'd10;
        tick;
        model[5] = 64'd10;
        rd_address = 5'd3; write_data = 64'd25;
        tick;
        model[3] = 64'd25;
        reg_write = 1'b0;
        rs1_address = 5'd3; rs2_address = 5'd5;
        exp_q.push_back(model_read(5'd3)); exp_q.push_back(model_read(5'd5)); exp_q.push_back(64'd0);
        #1;
        expv = exp_q.pop_front(); compared++;
        if (rs1_data !== expv) begin mismatched++; $display("[TB] FAIL basic_rs1: got %h expected %h", rs1_data, expv); end
        expv = exp_q.pop_front(); compared++;
        if (rs2_data !== expv) begin mismatched++; $display("[TB] FAIL basic_rs2: got %h expected %h", rs2_data, expv); end
        expv = exp_q.pop_front(); compared++;
        if (64'(write_dropped) !== expv) begin mismatched++; $display("[TB] FAIL basic_no_drop: got %h expected %h", write_dropped, expv); end
    endtask

    task automatic test_dropped;
        reg_write = 1'b1; rd_address = 5'd0; write_data = 64'd99; rs1_address = 5'd0;
        exp_q.push_back(64'd1); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        tick;
        reg_write = 1'b0;
        expv = exp_q.pop_front(); compared++;
        if (64'(write_dropped) !== expv) begin mismatched++; $display("[TB] FAIL x0_drop_pulse: got %h expected %h", write_dropped, expv); end
        expv = exp_q.pop_front(); compared++;
        if (rs1_data !== expv) begin mismatched++; $display("[TB] FAIL x0_reads_zero: got %h expected %h", rs1_data, expv); end
        tick;
        expv = exp_q.pop_front(); compared++;
        if (64'(write_dropped) !== expv) begin mismatched++; $display("[TB] FAIL x0_drop_one_cycle: got %h expected %h", write_dropped, expv); end
    endtask

    task automatic test_bypass;
        reg_write = 1'b1; rd_address = 5'd9; write_data = 64'h1234;
        rs1_address = 5'd9; rs2_address = 5'd5;
        exp_q.push_back(BYPASS ? 64'h1234 : model_read(5'd9));
        exp_q.push_back(model_read(5'd5));
        #1;
        expv = exp_q.pop_front(); compared++;
        if (rs1_data !== expv) begin mismatched++; $display("[TB] FAIL bypass_same_cycle: got %h expected %h", rs1_data, expv); end
        expv = exp_q.pop_front(); compared++;
        if (rs2_data !== expv) begin mismatched++; $display("[TB] FAIL bypass_other_port: got %h expected %h", rs2_data, expv); end
        tick;
        reg_write = 1'b0;
        model[9] = 64'h1234;
        exp_q.push_back(64'h1234);
        expv = exp_q.pop_front(); compared++;
        if (rs1_data !== expv) begin mismatched++; $display("[TB] FAIL bypass_after_edge: got %h expected %h", rs1_data, expv); end
    endtask

    // Random writes every cycle with reads frequently aimed at the write
    // target, checked against the reference model.
    task automatic test_back_to_back;
        for (int n = 0; n < 24; n++) begin
            logic [4:0]  wa;
            logic [4:0]  a1;
            logic [4:0]  a2;
            logic [63:0] wd;
            logic        we;
            logic [63:0] e1;
            logic [63:0] e2;
            we = 1'($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = {$urandom, $urandom};
            a1 = (n % 3 == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = (n % 4 == 1) ? wa : 5'($urandom_range(0, 31));
            reg_write = we; rd_address = wa; write_data = wd;
            rs1_address = a1; rs2_address = a2;
            e1 = model_read(a1);
            e2 = model_read(a2);
            if (BYPASS && we && wa != 5'd0 && a1 == wa) e1 = wd;
            if (BYPASS && we && wa != 5'd0 && a2 == wa) e2 = wd;
            exp_q.push_back(e1); exp_q.push_back(e2);
            exp_q.push_back(64'(we && wa == 5'd0));
            #1;
            expv = exp_q.pop_front(); compared++;
            if (rs1_data !== expv) begin mismatched++; $display("[TB] FAIL b2b_rs1 n=%0d: got %h expected %h", n, rs1_data, expv); end
            expv = exp_q.pop_front(); compared++;
            if (rs2_data !== expv) begin mismatched++; $display("[TB] FAIL b2b_rs2 n=%0d: got %h expected %h", n, rs2_data, expv); end
            tick;
            if (we && wa != 5'd0) model[wa] = wd;
            expv = exp_q.pop_front(); compared++;
            if (64'(write_dropped) !== expv) begin mismatched++; $display("[TB] FAIL b2b_drop n=%0d: got %h expected %h", n, write_dropped, expv); end
        end
        reg_write = 1'b0;
    endtask

    task automatic test_mid_sweep;
        reg_write = 1'b1; rd_address = 5'd3; write_data = 64'd77; reset = 1'b1;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        tick;
        reg_write = 1'b0; reset = 1'b0;
        expv = exp_q.pop_front(); compared++;
        if (64'(write_dropped) !== expv) begin mismatched++; $display("[TB] FAIL reset_wins_no_drop: got %h expected %h", write_dropped, expv); end
        expv = exp_q.pop_front(); compared++;
        if (64'(ready) !== expv) begin mismatched++; $display("[TB] FAIL reset_clears_ready: got %h expected %h", ready, expv); end

        for (int i = 1; i <= 10; i++) begin
            if (i == 5) begin reg_write = 1'b1; rd_address = 5'd4; write_data = 64'hAA; end
            exp_q.push_back(64'(i == 5)); exp_q.push_back(64'd0);
            tick;
            reg_write = 1'b0;
            expv = exp_q.pop_front(); compared++;
            if (64'(write_dropped) !== expv) begin mismatched++; $display("[TB] FAIL clear_drop edge %0d: got %h expected %h", i, write_dropped, expv); end
            expv = exp_q.pop_front(); compared++;
            if (64'(ready) !== expv) begin mismatched++; $display("[TB] FAIL clear_ready edge %0d: got %h expected %h", i, ready, expv); end
        end

        reset = 1'b1; tick; reset = 1'b0;
        rs1_address = 5'd31; rs2_address = 5'd4;
        for (int i = 1; i <= 32; i++) begin
            if (i == 32) begin reg_write = 1'b1; rd_address = 5'd31; write_data = 64'hFF; end
            exp_q.push_back(64'(i == 32));
            tick;
            reg_write = 1'b0;
            expv = exp_q.pop_front(); compared++;
            if (64'(ready) !== expv) begin mismatched++; $display("[TB] FAIL restart_ready edge %0d: got %h expected %h", i, ready, expv); end
        end
        exp_q.push_back(64'd1); exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        expv = exp_q.pop_front(); compared++;
        if (64'(write_dropped) !== expv) begin mismatched++; $display("[TB] FAIL final_edge_drop: got %h expected %h", write_dropped, expv); end
        expv = exp_q.pop_front(); compared++;
        if (rs1_data !== expv) begin mismatched++; $display("[TB] FAIL final_edge_x31: got %h expected %h", rs1_data, expv); end
        expv = exp_q.pop_front(); compared++;
        if (rs2_data !== expv) begin mismatched++; $display("[TB] FAIL clear_write_x4: got %h expected %h", rs2_data, expv); end
        tick;
        expv = exp_q.pop_front(); compared++;
        if (64'(write_dropped) !== expv) begin mismatched++; $display("[TB] FAIL final_drop_one_cycle: got %h expected %h", write_dropped, expv); end
        clear_model();
    endtask

    task automatic test_depth16;
        int edges;
        reset_16 = 1'b1; tick; reset_16 = 1'b0;
        exp_q.push_back(64'd16);
        edges = 0;
        while (ready_16 !== 1'b1 && edges < 100) begin tick; edges++; end
        expv = exp_q.pop_front(); compared++;
        if (64'(edges) !== expv) begin mismatched++; $display("[TB] FAIL d16_sweep_len: got %0d expected %0d", edges, expv); end

        reg_write_16 = 1'b1; rd_address_16 = 5'd20; write_data_16 = 64'h5555; rs1_address_16 = 5'd20;
        exp_q.push_back(64'd1); exp_q.push_back(64'd0);
        tick;
        expv = exp_q.pop_front(); compared++;
        if (64'(write_dropped_16) !== expv) begin mismatched++; $display("[TB] FAIL d16_x20_drop: got %h expected %h", write_dropped_16, expv); end
        expv = exp_q.pop_front(); compared++;
        if (rs1_data_16 !== expv) begin mismatched++; $display("[TB] FAIL d16_x20_reads_zero: got %h expected %h", rs1_data_16, expv); end

        rd_address_16 = 5'd15; write_data_16 = 64'hABCD; rs2_address_16 = 5'd15;
        exp_q.push_back(64'd0); exp_q.push_back(64'hABCD);
        tick;
        reg_write_16 = 1'b0;
        expv = exp_q.pop_front(); compared++;
        if (64'(write_dropped_16) !== expv) begin mismatched++; $display("[TB] FAIL d16_x15_no_drop: got %h expected %h", write_dropped_16, expv); end
        expv = exp_q.pop_front(); compared++;
        if (rs2_data_16 !== expv) begin mismatched++; $display("[TB] FAIL d16_x15_read: got %h expected %h", rs2_data_16, expv); end
    endtask

    task automatic test_width8;
        int edges;
        reset_8 = 1'b1; tick; reset_8 = 1'b0;
        exp_q.push_back(64'd8);
        edges = 0;
        while (ready_8 !== 1'b1 && edges < 100) begin tick; edges++; end
        expv = exp_q.pop_front(); compared++;
        if (64'(edges) !== expv) begin mismatched++; $display("[TB] FAIL w8_sweep_len: got %0d expected %0d", edges, expv); end

        reg_write_8 = 1'b1; rd_address_8 = 5'd0; write_data_8 = 32'hFFFF_FFFF; rs1_address_8 = 5'd0;
        exp_q.push_back(64'd0); exp_q.push_back(64'hFFFF_FFFF);
        tick;
        expv = exp_q.pop_front(); compared++;
        if (64'(write_dropped_8) !== expv) begin mismatched++; $display("[TB] FAIL w8_x0_no_drop: got %h expected %h", write_dropped_8, expv); end
        expv = exp_q.pop_front(); compared++;
        if (64'(rs1_data_8) !== expv) begin mismatched++; $display("[TB] FAIL w8_x0_read: got %h expected %h", rs1_data_8, expv); end

        rd_address_8 = 5'd8; write_data_8 = 32'h1357_9BDF; rs2_address_8 = 5'd8;
        exp_q.push_back(64'd1); exp_q.push_back(64'd0);
        tick;
        reg_write_8 = 1'b0;
        expv = exp_q.pop_front(); compared++;
        if (64'(write_dropped_8) !== expv) begin mismatched++; $display("[TB] FAIL w8_x8_drop: got %h expected %h", write_dropped_8, expv); end
        expv = exp_q.pop_front(); compared++;
        if (64'(rs2_data_8) !== expv) begin mismatched++; $display("[TB] FAIL w8_x8_reads_zero: got %h expected %h", rs2_data_8, expv); end
    endtask

    initial begin
        reset = 1'b1; reg_write = 1'b0; rd_address = '0; write_data = '0;
        rs1_address = '0; rs2_address = '0;
        reset_16 = 1'b1; reg_write_16 = 1'b0; rd_address_16 = '0; write_data_16 = '0;
        rs1_address_16 = '0; rs2_address_16 = '0;
        reset_8 = 1'b1; reg_write_8 = 1'b0; rd_address_8 = '0; write_data_8 = '0;
        rs1_address_8 = '0; rs2_address_8 = '0;
        clear_model();
        $display("[TB] regfile_param bench start, bypass=%0d", BYPASS);

        test_reset;
        test_basic_write;
        test_dropped;
        test_bypass;
        test_back_to_back;
        test_mid_sweep;
        test_depth16;
        test_width8;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
